// File: rtl/shift_register_pkg.sv
// Shared constants and helpers for the serial-in, parallel-out capture register.
// Counter width is derived from the chain width so a full frame fits.
package shift_register_pkg;

  localparam int SR_DEFAULT_WIDTH = 512;

  function automatic int sr_count_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_register.sv
// Serial-in, parallel-out capture register with load-time snapshot and preset.
// Optional SHIFT_REGISTER_BITCOUNT_EN adds a saturating shift counter.
module shift_register
  import shift_register_pkg::*;
#(
  parameter int WIDTH = SR_DEFAULT_WIDTH,
  localparam int CW = sr_count_width(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_in,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
`ifdef SHIFT_REGISTER_BITCOUNT_EN
  ,
  output logic [CW-1:0]    shift_count,
  output logic             frame_full
`endif
);

  logic [WIDTH-1:0] chain;
  logic [WIDTH-1:0] out_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain   <= '0;
      out_reg <= '0;
    end else if (load) begin
      out_reg <= chain;
      chain   <= data_in;
    end else begin
      chain   <= {chain[WIDTH-2:0], shift_in};
    end
  end

  assign data_out = out_reg;

`ifdef SHIFT_REGISTER_BITCOUNT_EN
  localparam logic [CW-1:0] FULL = CW'(WIDTH);

  logic [CW-1:0] cnt;

  // Saturates so frame_full stays asserted until the next load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (cnt != FULL) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign shift_count = cnt;
  assign frame_full  = (cnt == FULL);
`endif

endmodule

// File: tb/tb_shift_register.sv
// Directed scoreboard bench for shift_register (small WIDTH keeps runtime short).
// Counter checks are included when SHIFT_REGISTER_BITCOUNT_EN is defined.
module tb_shift_register;
  import shift_register_pkg::*;

  localparam int W  = 16;
  localparam int CW = sr_count_width(W);

  logic         clk;
  logic         reset;
  logic         shift_in;
  logic         load;
  logic [W-1:0] data_in;
  logic [W-1:0] data_out;
`ifdef SHIFT_REGISTER_BITCOUNT_EN
  logic [CW-1:0] shift_count;
  logic          frame_full;
`endif

  shift_register #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .shift_in (shift_in),
    .load     (load),
    .data_in  (data_in),
    .data_out (data_out)
`ifdef SHIFT_REGISTER_BITCOUNT_EN
    ,
    .shift_count (shift_count),
    .frame_full  (frame_full)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] sb[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag,
                       input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic shift(input logic b);
    shift_in = b;
    load     = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input string tag, input logic [W-1:0] exp);
    logic [W-1:0] e;
    load     = 1'b1;
    shift_in = 1'b1;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    load = 1'b0;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      check(tag, data_out, e);
    end
  endtask

  initial begin
    logic [W-1:0] ones;
    ones     = '1;
    reset    = 1'b1;
    shift_in = 1'b1;
    load     = 1'b0;
    data_in  = '1;

    // reset held: loads and shifts must have no effect
    repeat (4) begin
      @(posedge clk);
      #1;
      load = ~load;
    end
    check("rst_hold", data_out, '0);
    reset   = 1'b0;
    data_in = '0;
    do_load("rst_first_load", '0);

`ifdef SHIFT_REGISTER_BITCOUNT_EN
    check("cnt_after_load", W'(shift_count), '0);
`endif

    // walking one
    for (int i = 0; i < W; i++) begin
      shift(1'b1);
      repeat (i) shift(1'b0);
      do_load($sformatf("walk_%0d", i), W'(1) << i);
    end

    // preset then shift
    data_in = W'('hA5);
    do_load("preset_cap", '0);
    data_in = '0;
    repeat (4) shift(1'b0);
    check("hold_between_loads", data_out, '0);
    do_load("preset_shift", W'('hA50));

    // back-to-back loads
    data_in = W'('h3C96);
    do_load("b2b_first", '0);
    data_in = W'('h0F0F);
    do_load("b2b_second", W'('h3C96));
    data_in = '0;
    do_load("b2b_third", W'('h0F0F));

    // overflow past MSB
    repeat (W + 3) shift(1'b1);
    do_load("ovf_ones", ones);
    repeat (W) shift(1'b0);
    do_load("ovf_zeros", '0);

    // async reset mid-frame
    repeat (W) shift(1'b1);
    do_load("pre_async", ones);
    repeat (10) shift(1'b1);
    check("hold_pre_async", data_out, ones);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_out", data_out, '0);
`ifdef SHIFT_REGISTER_BITCOUNT_EN
    check("async_rst_cnt", W'(shift_count), '0);
`endif
    #1;
    reset = 1'b0;
    do_load("post_async_load", '0);

`ifdef SHIFT_REGISTER_BITCOUNT_EN
    repeat (5) shift(1'b1);
    check("cnt_5", W'(shift_count), W'(5));
    check("full_5", W'(frame_full), '0);
    repeat (W + 2) shift(1'b0);
    check("cnt_sat", W'(shift_count), W'(W));
    check("full_sat", W'(frame_full), W'(1));
    do_load("cnt_load", '0);
    check("cnt_clr", W'(shift_count), '0);
    check("full_clr", W'(frame_full), '0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
